alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU; one operation in flight at a time.
// Define ALU_ARBITER_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise requester 0 has priority.
module alu_arbiter (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_opA,
  input  logic [31:0] req0_opB,
  input  logic [31:0] req1_opA,
  input  logic [31:0] req1_opB,
  input  logic [4:0]  req0_opcode,
  input  logic [4:0]  req1_opcode,
  input  logic [4:0]  req0_shamt,
  input  logic [4:0]  req1_shamt,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  input  logic        rsp0_ready,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_isNotEqual,
  output logic        rsp_isLessThan,
  output logic        rsp_overflow,
  output logic [31:0] alu_operandA,
  output logic [31:0] alu_operandB,
  output logic [4:0]  alu_opcode,
  output logic [4:0]  alu_shiftamt,
  input  logic [31:0] alu_result,
  input  logic        alu_isNotEqual,
  input  logic        alu_isLessThan,
  input  logic        alu_overflow,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  logic [31:0] r_opa;
  logic [31:0] r_opb;
  logic [4:0]  r_opcode;
  logic [4:0]  r_shamt;
  logic        r_owner;
  logic [31:0] r_result;
  logic        r_ne;
  logic        r_lt;
  logic        r_ovf;

  logic w_idle;
  logic w_grant0;
  logic w_grant1;
  logic w_accept;
  logic w_rsp_take;

  assign w_idle = (r_state == ST_IDLE);

`ifdef ALU_ARBITER_ROUND_ROBIN_EN
  logic r_last;  // 1 when requester 1 was served most recently

  assign w_grant0 = w_idle && req0_valid && (!req1_valid || r_last);
  assign w_grant1 = w_idle && req1_valid && (!req0_valid || !r_last);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_last <= 1'b1;
    end else if (w_accept) begin
      r_last <= w_grant1;
    end
  end
`else
  assign w_grant0 = w_idle && req0_valid;
  assign w_grant1 = w_idle && req1_valid && !req0_valid;
`endif

  assign w_accept   = w_grant0 || w_grant1;
  assign w_rsp_take = (r_state == ST_RESP) && (r_owner ? rsp1_ready : rsp0_ready);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_next = ST_EXEC;
      ST_EXEC: w_state_next = ST_RESP;
      ST_RESP: if (w_rsp_take) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_opa    <= '0;
      r_opb    <= '0;
      r_opcode <= '0;
      r_shamt  <= '0;
      r_owner  <= 1'b0;
    end else if (w_accept) begin
      r_opa    <= w_grant1 ? req1_opA    : req0_opA;
      r_opb    <= w_grant1 ? req1_opB    : req0_opB;
      r_opcode <= w_grant1 ? req1_opcode : req0_opcode;
      r_shamt  <= w_grant1 ? req1_shamt  : req0_shamt;
      r_owner  <= w_grant1;
    end
  end

  // The ALU sees only latched operands, so its result is settled by the end of EXEC.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_result <= '0;
      r_ne     <= 1'b0;
      r_lt     <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_result <= alu_result;
      r_ne     <= alu_isNotEqual;
      r_lt     <= alu_isLessThan;
      r_ovf    <= alu_overflow;
    end
  end

  assign req0_ready     = w_grant0;
  assign req1_ready     = w_grant1;
  assign rsp0_valid     = (r_state == ST_RESP) && !r_owner;
  assign rsp1_valid     = (r_state == ST_RESP) && r_owner;
  assign rsp_result     = r_result;
  assign rsp_isNotEqual = r_ne;
  assign rsp_isLessThan = r_lt;
  assign rsp_overflow   = r_ovf;
  assign alu_operandA   = r_opa;
  assign alu_operandB   = r_opb;
  assign alu_opcode     = r_opcode;
  assign alu_shiftamt   = r_shamt;
  assign busy           = !w_idle;

endmodule
